forward_hazard_unit: RTL and testbench



---
 rtl/fwd_pkg.sv | 37 +++
 rtl/fwd_match.sv | 39 +++
 rtl/forward_hazard_unit.sv | 105 ++++++++++
 tb/tb_forward_hazard_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types for the forwarding / hazard unit
package fwd_pkg;

    // Largest operand count and address width any instance may use; stage tags
    // are sized to these so one struct type serves every parameterisation.
    localparam int MAX_SRC = 4;
    localparam int MAX_AW  = 8;

    typedef logic [MAX_AW-1:0] addr_t;

    typedef enum logic [1:0] {
        REG      = 2'b00,
        MEM_ALU  = 2'b01,
        WB       = 2'b10,
        MEM_DATA = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic                     valid;
        logic [MAX_SRC-1:0][MAX_AW-1:0] src;
        logic [MAX_SRC-1:0]       src_used;
        addr_t                    dst;
        logic                     regwrite;
        logic                     memread;
    } tag_t;

    // Zero register is the all-ones address of an aw-bit register file,
    // zero-extended to the tag width.
    function automatic addr_t zero_reg(int aw);
        addr_t r;
        for (int i = 0; i < MAX_AW; i++) begin
            r[i] = (i < aw);
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - per-source forwarding priority compare
module fwd_match
    import fwd_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [MAX_AW-1:0] src,
    input  logic              src_used,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic [MAX_AW-1:0] mem_dst,
    input  logic              wb_valid,
    input  logic              wb_regwrite,
    input  logic [MAX_AW-1:0] wb_dst,
    output logic [1:0]        sel
);

    localparam addr_t ZR = zero_reg(AW);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_valid && mem_regwrite && (mem_dst == src) && (mem_dst != ZR);
    assign wb_hit  = wb_valid  && wb_regwrite  && (wb_dst  == src) && (wb_dst  != ZR);

    // Youngest producer wins: MEM before WB, register file otherwise.
    always_comb begin
        sel = REG;
        if (src_used && (src != ZR)) begin
            if (mem_hit) begin
                sel = mem_memread ? MEM_DATA : MEM_ALU;
            end else if (wb_hit) begin
                sel = WB;
            end
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - EX/MEM/WB tag pipeline with operand forwarding and load-use stall
module forward_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int AW         = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   id_valid,
    input  logic [NUM_SRC*AW-1:0]  id_src,
    input  logic [NUM_SRC-1:0]     id_src_used,
    input  logic [AW-1:0]          id_dst,
    input  logic                   id_regwrite,
    input  logic                   id_memread,
    input  logic                   flush,
    output logic [2*NUM_SRC-1:0]   fwd_sel,
    output logic                   stall,
    output logic                   ex_valid,
    output logic                   mem_valid,
    output logic                   wb_valid,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam addr_t ZR = zero_reg(AW);

    tag_t id_tag;
    tag_t ex_tag;
    tag_t mem_tag;
    tag_t wb_tag;
    logic load_use;

    // Pack the decode-stage inputs into a stage tag.
    always_comb begin
        id_tag          = '0;
        id_tag.valid    = id_valid;
        for (int i = 0; i < NUM_SRC; i++) begin
            id_tag.src[i]      = MAX_AW'(id_src[i*AW +: AW]);
            id_tag.src_used[i] = id_src_used[i];
        end
        id_tag.dst      = MAX_AW'(id_dst);
        id_tag.regwrite = id_regwrite;
        id_tag.memread  = id_memread;
    end

    // A load in EX whose result a decode-stage operand needs.
    always_comb begin
        load_use = 1'b0;
        if (ex_tag.valid && ex_tag.memread && ex_tag.regwrite && (ex_tag.dst != ZR)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (id_tag.src_used[i] && (id_tag.src[i] == ex_tag.dst)) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    // Flush wins over stall; without the stall mode, MEM_DATA forwarding covers loads.
    assign stall = (LOAD_STALL != 0) && id_valid && !flush && load_use;

    // Advance the tag pipeline; stalled or flushed decode slots enter EX as bubbles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_tag  <= '0;
            mem_tag <= '0;
            wb_tag  <= '0;
        end else begin
            wb_tag  <= mem_tag;
            mem_tag <= ex_tag;
            ex_tag  <= (id_valid && !stall && !flush) ? id_tag : '0;
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    genvar g;
    for (g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_match #(.AW(AW)) u_match (
            .src          (ex_tag.src[g]),
            .src_used     (ex_tag.src_used[g]),
            .mem_valid    (mem_tag.valid),
            .mem_regwrite (mem_tag.regwrite),
            .mem_memread  (mem_tag.memread),
            .mem_dst      (mem_tag.dst),
            .wb_valid     (wb_tag.valid),
            .wb_regwrite  (wb_tag.regwrite),
            .wb_dst       (wb_tag.dst),
            .sel          (fwd_sel[2*g +: 2])
        );
    end

    assign ex_valid  = ex_tag.valid;
    assign mem_valid = mem_tag.valid;
    assign wb_valid  = wb_tag.valid;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb/tb_forward_hazard_unit.sv - self-checking bench for forward_hazard_unit
module tb_forward_hazard_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [9:0] id_src;
    logic [1:0] id_src_used;
    logic [4:0] id_dst;
    logic       id_regwrite;
    logic       id_memread;
    logic       flush;

    logic [3:0] fwd_a, fwd_b;
    logic       stall_a, stall_b;
    logic       exv_a, memv_a, wbv_a;
    logic       exv_b, memv_b, wbv_b;
    logic [3:0] cnt_a, cnt_b;

    always #5 clk = ~clk;

    forward_hazard_unit #(.NUM_SRC(2), .AW(5), .LOAD_STALL(1), .CNT_W(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_dst(id_dst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush), .fwd_sel(fwd_a), .stall(stall_a),
        .ex_valid(exv_a), .mem_valid(memv_a), .wb_valid(wbv_a), .stall_cnt(cnt_a)
    );

    forward_hazard_unit #(.NUM_SRC(2), .AW(5), .LOAD_STALL(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_dst(id_dst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush), .fwd_sel(fwd_b), .stall(stall_b),
        .ex_valid(exv_b), .mem_valid(memv_b), .wb_valid(wbv_b), .stall_cnt(cnt_b)
    );

    typedef struct {
        bit       v;
        int       s0;
        int       s1;
        bit [1:0] u;
        int       d;
        bit       rw;
        bit       mr;
    } ins_t;

    typedef struct {
        ins_t       i;
        bit         fl;
        logic [3:0] fa;
        bit         sa;
        logic [3:0] fb;
        bit         sb;
    } vec_t;

    // Model: per DUT (0 = stall mode, 1 = forward-load mode) the instructions
    // currently occupying EX, MEM, WB, youngest first.
    ins_t pipe[2][$];
    int   mcnt[2];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic ins_t mk(bit v, int s0, int s1, bit [1:0] u, int d, bit rw, bit mr);
        ins_t r;
        r.v = v; r.s0 = s0; r.s1 = s1; r.u = u; r.d = d; r.rw = rw; r.mr = mr;
        return r;
    endfunction

    function automatic ins_t bub();
        return mk(0, 0, 0, 2'b00, 0, 0, 0);
    endfunction

    task automatic m_reset();
        for (int m = 0; m < 2; m++) begin
            pipe[m].delete();
            repeat (3) pipe[m].push_back(bub());
            mcnt[m] = 0;
        end
    endtask

    // Select code for one EX operand: nearest older writer of that register.
    function automatic int src_code(int m, int s, bit used);
        if (!used || s == 31) return 0;
        for (int k = 1; k <= 2; k++) begin
            if (pipe[m][k].v && pipe[m][k].rw && pipe[m][k].d == s)
                return (k == 1) ? (pipe[m][k].mr ? 3 : 1) : 2;
        end
        return 0;
    endfunction

    function automatic int m_fwd(int m);
        return src_code(m, pipe[m][0].s1, pipe[m][0].u[1]) * 4
             + src_code(m, pipe[m][0].s0, pipe[m][0].u[0]);
    endfunction

    function automatic bit m_stall(int m, ins_t id, bit fl);
        ins_t ex;
        ex = pipe[m][0];
        if (m == 1 || fl || !id.v) return 0;
        if (!(ex.v && ex.mr && ex.rw && ex.d != 31)) return 0;
        return (id.u[0] && id.s0 == ex.d) || (id.u[1] && id.s1 == ex.d);
    endfunction

    task automatic m_step(int m, ins_t id, bit fl, bit st);
        pipe[m].push_front((id.v && !st && !fl) ? id : bub());
        void'(pipe[m].pop_back());
        if (st && mcnt[m] < 15) mcnt[m]++;
    endtask

    task automatic drive(input ins_t id, input bit fl);
        id_valid    = id.v;
        id_src      = {5'(id.s1), 5'(id.s0)};
        id_src_used = id.u;
        id_dst      = 5'(id.d);
        id_regwrite = id.rw;
        id_memread  = id.mr;
        flush       = fl;
    endtask

    // Entered just after a rising edge; checks mid-cycle, then clocks the model.
    task automatic run_cycle(input ins_t id, input bit fl,
                             output logic [3:0] fa, output logic sa,
                             output logic [3:0] fb, output logic sb);
        bit e0, e1;
        drive(id, fl);
        #2;
        e0 = m_stall(0, id, fl);
        e1 = m_stall(1, id, fl);
        chk("fwd_a",   int'(fwd_a), m_fwd(0));
        chk("stall_a", int'(stall_a), int'(e0));
        chk("valid_a", int'({exv_a, memv_a, wbv_a}), int'({pipe[0][0].v, pipe[0][1].v, pipe[0][2].v}));
        chk("cnt_a",   int'(cnt_a), mcnt[0]);
        chk("fwd_b",   int'(fwd_b), m_fwd(1));
        chk("stall_b", int'(stall_b), int'(e1));
        chk("valid_b", int'({exv_b, memv_b, wbv_b}), int'({pipe[1][0].v, pipe[1][1].v, pipe[1][2].v}));
        chk("cnt_b",   int'(cnt_b), mcnt[1]);
        fa = fwd_a; sa = stall_a; fb = fwd_b; sb = stall_b;
        @(posedge clk);
        m_step(0, id, fl, e0);
        m_step(1, id, fl, e1);
        cyc++;
        #1;
    endtask

    task automatic add(input ins_t i, input bit fl, input logic [3:0] fa, input bit sa,
                       input logic [3:0] fb, input bit sb);
        vec_t v;
        v.i = i; v.fl = fl; v.fa = fa; v.sa = sa; v.fb = fb; v.sb = sb;
        tbl.push_back(v);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_fwd_a"},   int'(fwd_a), 0);
        chk({tag, "_stall_a"}, int'(stall_a), 0);
        chk({tag, "_valid_a"}, int'({exv_a, memv_a, wbv_a}), 0);
        chk({tag, "_cnt_a"},   int'(cnt_a), 0);
        chk({tag, "_fwd_b"},   int'(fwd_b), 0);
        chk({tag, "_valid_b"}, int'({exv_b, memv_b, wbv_b}), 0);
    endtask

    function automatic int rnd_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 31 : r;
    endfunction

    initial begin
        logic [3:0] fa, fb;
        logic       sa, sb;
        ins_t       ld;

        // Directed vectors: {instruction, flush, fwd_a, stall_a, fwd_b, stall_b}.
        add(mk(1, 5, 6, 2'b11, 1, 1, 0),   0, 4'b0000, 0, 4'b0000, 0); // ADD X1
        add(mk(1, 1, 1, 2'b11, 2, 1, 0),   0, 4'b0000, 0, 4'b0000, 0); // ADD X2,X1,X1
        add(mk(1, 1, 9, 2'b11, 7, 1, 0),   0, 4'b0101, 0, 4'b0101, 0); // reader X1
        add(bub(),                         0, 4'b0010, 0, 4'b0010, 0);
        add(mk(1, 10, 0, 2'b01, 3, 1, 1),  0, 4'b0000, 0, 4'b0000, 0); // LDUR X3
        add(mk(1, 3, 12, 2'b11, 11, 1, 0), 0, 4'b0000, 1, 4'b0000, 0); // use X3
        add(mk(1, 3, 12, 2'b11, 11, 1, 0), 0, 4'b0000, 0, 4'b0011, 0); // held consumer
        // After the bubble the load has reached WB, so the consumer takes the WB path.
        add(bub(),                         0, 4'b0010, 0, 4'b0010, 0);
        add(mk(1, 1, 2, 2'b11, 31, 1, 0),  0, 4'b0000, 0, 4'b0000, 0); // write X31
        add(mk(1, 5, 0, 2'b01, 31, 1, 1),  0, 4'b0000, 0, 4'b0000, 0); // load X31
        add(mk(1, 31, 31, 2'b11, 8, 1, 0), 0, 4'b0000, 0, 4'b0000, 0); // read X31
        add(bub(),                         0, 4'b0000, 0, 4'b0000, 0);
        add(mk(1, 1, 1, 2'b11, 4, 1, 0),   0, 4'b0000, 0, 4'b0000, 0); // write X4
        add(mk(1, 2, 2, 2'b11, 4, 1, 0),   0, 4'b0000, 0, 4'b0000, 0); // write X4
        add(mk(1, 4, 4, 2'b11, 9, 1, 0),   0, 4'b0000, 0, 4'b0000, 0); // read X4
        add(bub(),                         0, 4'b0101, 0, 4'b0101, 0);
        add(mk(1, 6, 0, 2'b01, 5, 1, 1),   0, 4'b0000, 0, 4'b0000, 0); // LDUR X5
        add(mk(1, 5, 5, 2'b11, 10, 1, 0),  1, 4'b0000, 0, 4'b0000, 0); // use X5 + flush
        add(bub(),                         0, 4'b0000, 0, 4'b0000, 0);

        // Reset state with a would-be hazard on the inputs.
        reset_n = 1'b0;
        drive(mk(1, 1, 1, 2'b11, 1, 1, 1), 0);
        m_reset();
        #12;
        chk_reset_outputs("reset");
        reset_n = 1'b1;

        foreach (tbl[k]) begin
            run_cycle(tbl[k].i, tbl[k].fl, fa, sa, fb, sb);
            chk($sformatf("vec%0d_fwd_a", k),   int'(fa), int'(tbl[k].fa));
            chk($sformatf("vec%0d_stall_a", k), int'(sa), int'(tbl[k].sa));
            chk($sformatf("vec%0d_fwd_b", k),   int'(fb), int'(tbl[k].fb));
            chk($sformatf("vec%0d_stall_b", k), int'(sb), int'(tbl[k].sb));
        end
        chk("cnt_after_one_pair", int'(cnt_a), 1);

        // Random traffic over a small register pool, including X31.
        for (int n = 0; n < 400; n++) begin
            ins_t r;
            r = mk($urandom_range(0, 7) != 0, rnd_reg(), rnd_reg(), 2'($urandom),
                   rnd_reg(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            run_cycle(r, $urandom_range(0, 9) == 0, fa, sa, fb, sb);
        end

        // Saturation: back-to-back dependent loads stall every other cycle.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        m_reset();
        ld = mk(1, 1, 1, 2'b01, 1, 1, 1);
        for (int n = 0; n < 60; n++) run_cycle(ld, 0, fa, sa, fb, sb);
        chk("cnt_saturated_a", int'(cnt_a), 15);
        chk("cnt_never_b", int'(cnt_b), 0);

        // Asynchronous reset in the middle of a stall cycle.
        run_cycle(bub(), 0, fa, sa, fb, sb);
        run_cycle(ld, 0, fa, sa, fb, sb);
        drive(ld, 0);
        #2;
        chk("pre_reset_stall", int'(stall_a), 1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        drive(bub(), 0);
        reset_n = 1'b1;
        m_reset();
        run_cycle(bub(), 0, fa, sa, fb, sb);
        run_cycle(ld, 0, fa, sa, fb, sb);
        run_cycle(ld, 0, fa, sa, fb, sb);
        chk("post_reset_stall", int'(sa), 1);
        run_cycle(bub(), 0, fa, sa, fb, sb);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
